seg7_scan2: RTL and testbench
=============================

// Module: seg7_scan2
// PURPOSE
//  Display stage downstream of the 2-digit BCD counter. Drives a 2-digit
//  multiplexed common-anode/cathode 7-segment display from the units/tens BCD
//  digits. A dead-time gap between digits suppresses ghosting. Digits are
//  snapshotted once per frame so both digits always come from the same count.
// PARAMETERS
//  SCAN_DIV       50000  clk cycles each digit is lit (>=1)
//  GAP_CYC        4      clk cycles of blanking after each digit (>=1)
//  SEG_ACTIVE_LOW 1      1: seg/dp pins driven low = lit; 0: high = lit
//  DIG_ACTIVE_LOW 1      1: dig pins driven low = selected; 0: high = selected
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset_n    in   1  asynchronous active-low reset
//  cnt0       in   4  units BCD digit from counter
//  cnt1       in   4  tens BCD digit from counter
//  cout1      in   1  counter 99->00 carry pulse (present only with SEG_OVF_DP_EN)
//  seg        out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
//  dp         out  1  decimal point, polarity per SEG_ACTIVE_LOW
//  dig        out  2  digit enables, dig[0]=units, dig[1]=tens, per DIG_ACTIVE_LOW
//  frame_tick out  1  one-cycle pulse when a new snapshot is taken
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low (reset_n).
//  - FSM states: SHOW0 -> GAP0 -> SHOW1 -> GAP1 -> SHOW0. Dwell counter
//    counts 0..SCAN_DIV-1 in SHOWx, 0..GAP_CYC-1 in GAPx; state advances and
//    counter clears on the terminal count. Frame = 2*(SCAN_DIV+GAP_CYC) cycles.
//  - Reset: state=GAP1, dwell=0, shadow digits=0, ovf flag=0; all outputs
//    inactive (no segment lit, no digit selected, dp off, frame_tick=0).
//    First SHOW0 begins GAP_CYC cycles after reset_n deasserts.
//  - Snapshot: on the edge GAP1->SHOW0, cnt0/cnt1 sampled into shadow regs;
//    frame_tick=1 for exactly that following cycle. Input changes at any other
//    time have no visible effect until the next frame.
//  - Outputs are pure decode of registered state + shadow regs; no comb path
//    from cnt0/cnt1/cout1 to any output. Latency input->pins: <= 1 frame + 1 clk.
//  - SHOW0: dig[0] selected, seg = decode(shadow0). SHOW1: dig[1] selected,
//    seg = decode(shadow1). GAPx: no digit selected, all segments off.
//  - Decode (active-high, {g..a}): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
//    8=7F 9=6F; codes 10..15 show dash = 40. Polarity inversion applied last.
//  - Leading-zero blank: in SHOW1 with shadow1==0, dig stays deselected and
//    seg all off (timing unchanged). Units digit never blanked.
//  - Reset mid-frame: immediate return to reset values, asynchronous to clk.
//  - Counter wrap mid-frame (e.g. 99->00): displayed value changes only at
//    next snapshot; tearing (e.g. "90") must never appear.
// CONFIGURATION
//  SEG_OVF_DP_EN defined: cout1 port exists; a sticky ovf flag sets on the
//    clk edge where cout1==1, clears only on reset; while set, dp is lit
//    during SHOW1 (even if tens digit is leading-zero blanked). Both dp and
//    dig[1] are active then.
//  SEG_OVF_DP_EN undefined: no cout1 port, no ovf flag; dp permanently off.
// TESTING  (SCAN_DIV=8, GAP_CYC=2, SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1)
//  1 reset_n low -> seg=7F, dp=1, dig=11, frame_tick=0; release -> frame_tick
//    pulses 2 clks later, then dig=10 for 8 clks, 11 for 2, 01 for 8, 11 for 2.
//  2 cnt1=4,cnt0=7 held -> SHOW0 seg=~07=78, SHOW1 seg=~66=19; frame 20 clks.
//  3 cnt1=0,cnt0=5 -> SHOW0 seg=12 dig=10; SHOW1 dig=11 seg=7F.
//  4 change cnt0 3->9 mid-SHOW0 -> seg stays ~4F until next frame_tick, then ~6F.
//  5 cnt0=12 -> units shows dash seg=3F; reset_n pulsed mid-SHOW1 -> outputs
//    inactive same cycle, resume per scenario 1.
//  6 SEG_OVF_DP_EN: pulse cout1 one clk -> dp=0 in every later SHOW1, dp=1
//    elsewhere, until reset; without macro dp constantly 1.

Source files
------------

// File: rtl/seg7_scan2.sv
// Two-digit multiplexed 7-segment scanner with dead-time gaps and a per-frame digit snapshot.
// Define SEG_OVF_DP_EN to add the cout1 port and a sticky overflow flag shown on the tens dp.
module seg7_scan2 #(
    parameter int SCAN_DIV       = 50000,
    parameter int GAP_CYC        = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] cnt0,
    input  logic [3:0] cnt1,
`ifdef SEG_OVF_DP_EN
    input  logic       cout1,
`endif
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] dig,
    output logic       frame_tick
);

    localparam int MAX_DWELL = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
    localparam int CNT_W     = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
    localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    typedef enum logic [1:0] {SHOW0, GAP0, SHOW1, GAP1} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [3:0]       shadow0_q, shadow0_d;
    logic [3:0]       shadow1_q, shadow1_d;
    logic             frame_tick_q, frame_tick_d;
    logic             ovf_q, ovf_d;
    logic             term;
    logic             snap;
    logic [6:0]       seg_on;
    logic [1:0]       dig_on;
    logic             dp_on;

    function automatic logic [6:0] decode(input logic [3:0] bcd);
        case (bcd)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q + CNT_W'(1);
        term    = (state_q == SHOW0 || state_q == SHOW1) ? (dwell_q == SHOW_LAST)
                                                         : (dwell_q == GAP_LAST);
        if (term) begin
            dwell_d = '0;
            case (state_q)
                SHOW0:   state_d = GAP0;
                GAP0:    state_d = SHOW1;
                SHOW1:   state_d = GAP1;
                default: state_d = SHOW0;
            endcase
        end
        // Both digits are captured on the same edge so a mid-frame count change cannot tear.
        snap         = (state_q == GAP1) && term;
        shadow0_d    = snap ? cnt0 : shadow0_q;
        shadow1_d    = snap ? cnt1 : shadow1_q;
        frame_tick_d = snap;
`ifdef SEG_OVF_DP_EN
        ovf_d        = ovf_q | cout1;
`else
        ovf_d        = 1'b0;
`endif
    end

    // NOTE: state uses non-blocking assignments; reset also clears the shadow digits so the first frame is defined.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= GAP1;
            dwell_q      <= '0;
            shadow0_q    <= '0;
            shadow1_q    <= '0;
            frame_tick_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_q      <= dwell_d;
            shadow0_q    <= shadow0_d;
            shadow1_q    <= shadow1_d;
            frame_tick_q <= frame_tick_d;
            ovf_q        <= ovf_d;
        end
    end

    // Pin decode from registered state only; the tens digit is blanked when it is a leading zero.
    always_comb begin
        seg_on = '0;
        dig_on = '0;
        dp_on  = (state_q == SHOW1) && ovf_q;
        case (state_q)
            SHOW0: begin
                seg_on = decode(shadow0_q);
                dig_on = 2'b01;
            end
            SHOW1: begin
                if (shadow1_q != 4'd0) begin
                    seg_on = decode(shadow1_q);
                    dig_on = 2'b10;
                end
            end
            default: ;
        endcase
        seg        = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        dp         = SEG_ACTIVE_LOW ? ~dp_on  : dp_on;
        dig        = DIG_ACTIVE_LOW ? ~dig_on : dig_on;
        frame_tick = frame_tick_q;
    end

endmodule

// File: tb/tb_seg7_scan2.sv
// Self-checking bench for seg7_scan2: random digits checked every cycle against a frame-position model.
// Honours SEG_OVF_DP_EN the same way as the design.
module tb_seg7_scan2;

    localparam int SCAN  = 8;
    localparam int GAP   = 2;
    localparam int FRAME = 2 * (SCAN + GAP);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] cnt0 = '0;
    logic [3:0] cnt1 = '0;
    logic       cout1 = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] dig;
    logic       frame_tick;

    int n_checks = 0;
    int n_errors = 0;

    // Model: edges since reset release, latest snapshot, sticky overflow.
    int         m_k = 0;
    logic [3:0] m_sh0 = '0;
    logic [3:0] m_sh1 = '0;
    logic       m_ovf = 1'b0;

    logic [6:0] seg_tab [16];

    seg7_scan2 #(
        .SCAN_DIV(SCAN), .GAP_CYC(GAP), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cnt0(cnt0), .cnt1(cnt1),
`ifdef SEG_OVF_DP_EN
        .cout1(cout1),
`endif
        .seg(seg), .dp(dp), .dig(dig), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Expected {seg, dp, dig, frame_tick} from the position within the frame.
    function automatic logic [10:0] exp_out();
        logic [6:0] s;
        logic       d;
        logic [1:0] g;
        logic       t;
        int         o;
        s = '0; d = 1'b0; g = '0; t = 1'b0;
        if (m_k >= GAP) begin
            o = (m_k - GAP) % FRAME;
            t = (o == 0);
            if (o < SCAN) begin
                s = seg_tab[m_sh0];
                g = 2'b01;
            end else if (o >= SCAN + GAP && o < 2 * SCAN + GAP) begin
                d = m_ovf;
                if (m_sh1 != 0) begin
                    s = seg_tab[m_sh1];
                    g = 2'b10;
                end
            end
        end
        return {~s, ~d, ~g, t};
    endfunction

    function automatic int frame_pos();
        return (m_k < GAP) ? -1 : (m_k - GAP) % FRAME;
    endfunction

    // One clock: model follows the edge, then returns at the falling edge for sampling.
    task automatic advance();
        @(posedge clk);
        if (reset_n) begin
            m_k++;
            if (m_k >= GAP && (m_k - GAP) % FRAME == 0) begin
                m_sh0 = cnt0;
                m_sh1 = cnt1;
            end
`ifdef SEG_OVF_DP_EN
            if (cout1) m_ovf = 1'b1;
`endif
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_k = 0; m_sh0 = '0; m_sh1 = '0; m_ovf = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (seg !== 7'h7F) begin n_errors++; $display("FAIL reset_seg got=%h exp=7f", seg); end
        n_checks++;
        if (dp !== 1'b1) begin n_errors++; $display("FAIL reset_dp got=%b exp=1", dp); end
        n_checks++;
        if (dig !== 2'b11) begin n_errors++; $display("FAIL reset_dig got=%b exp=11", dig); end
        n_checks++;
        if (frame_tick !== 1'b0) begin n_errors++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    endtask

    task automatic test_scan_timing();
        int last_tick;
        cnt1 = 4'd4; cnt0 = 4'd7;
        reset_n = 1'b1;
        last_tick = -1;
        for (int c = 1; c <= 3 * FRAME; c++) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL scan_timing cyc=%0d got=%h exp=%h", c, {seg, dp, dig, frame_tick}, exp_out());
            end
            if (frame_tick === 1'b1) begin
                if (last_tick < 0) begin
                    n_checks++;
                    if (c !== GAP) begin n_errors++; $display("FAIL first_tick cyc=%0d exp=%0d", c, GAP); end
                end else begin
                    n_checks++;
                    if (c - last_tick !== FRAME) begin
                        n_errors++; $display("FAIL frame_len got=%0d exp=%0d", c - last_tick, FRAME);
                    end
                end
                last_tick = c;
            end
            if (frame_pos() == 3) begin
                n_checks++;
                if (seg !== 7'h78) begin n_errors++; $display("FAIL show0_seg7 got=%h exp=78", seg); end
            end
            if (frame_pos() == SCAN + GAP + 3) begin
                n_checks++;
                if (seg !== 7'h19) begin n_errors++; $display("FAIL show1_seg4 got=%h exp=19", seg); end
            end
        end
    endtask

    task automatic test_leading_zero();
        cnt1 = 4'd0; cnt0 = 4'd5;
        repeat (2 * FRAME) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL leading_zero pos=%0d got=%h exp=%h", frame_pos(), {seg, dp, dig, frame_tick}, exp_out());
            end
        end
    endtask

    task automatic test_random_inputs();
        repeat (8 * FRAME) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL random_hold pos=%0d got=%h exp=%h", frame_pos(), {seg, dp, dig, frame_tick}, exp_out());
            end
            cnt0 = 4'($urandom_range(0, 15));
            cnt1 = 4'($urandom_range(0, 15));
        end
    endtask

    task automatic test_dash();
        for (int f = 0; f < 3; f++) begin
            cnt0 = 4'($urandom_range(10, 15));
            cnt1 = 4'($urandom_range(10, 15));
            repeat (FRAME) begin
                advance();
                n_checks++;
                if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                    n_errors++;
                    $display("FAIL dash pos=%0d got=%h exp=%h", frame_pos(), {seg, dp, dig, frame_tick}, exp_out());
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        cnt1 = 4'd3; cnt0 = 4'd1;
        guard = 0;
        while (frame_pos() != SCAN + GAP + 3 && guard < 3 * FRAME) begin
            advance();
            guard++;
        end
        n_checks++;
        if (guard >= 3 * FRAME) begin n_errors++; $display("FAIL reset_mid_align guard=%0d", guard); end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({seg, dp, dig, frame_tick} !== {7'h7F, 1'b1, 2'b11, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_async got=%h exp=%h", {seg, dp, dig, frame_tick}, {7'h7F, 1'b1, 2'b11, 1'b0});
        end
        @(negedge clk);
        advance();
        reset_n = 1'b1;
        repeat (2 * FRAME) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL reset_resume k=%0d got=%h exp=%h", m_k, {seg, dp, dig, frame_tick}, exp_out());
            end
        end
    endtask

`ifdef SEG_OVF_DP_EN
    task automatic test_ovf();
        cnt1 = 4'd0; cnt0 = 4'd0;
        repeat (5) advance();
        cout1 = 1'b1;
        advance();
        cout1 = 1'b0;
        n_checks++;
        if (m_ovf !== 1'b1) begin n_errors++; $display("FAIL ovf_model got=%b exp=1", m_ovf); end
        repeat (3 * FRAME) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL ovf_dp pos=%0d got=%h exp=%h", frame_pos(), {seg, dp, dig, frame_tick}, exp_out());
            end
            if (frame_pos() == 2 * SCAN + GAP - 1) cnt1 = 4'($urandom_range(0, 9));
        end
        reset_n = 1'b0;
        model_reset();
        advance();
        reset_n = 1'b1;
        repeat (2 * FRAME) begin
            advance();
            n_checks++;
            if ({seg, dp, dig, frame_tick} !== exp_out()) begin
                n_errors++;
                $display("FAIL ovf_cleared pos=%0d got=%h exp=%h", frame_pos(), {seg, dp, dig, frame_tick}, exp_out());
            end
        end
    endtask
`endif

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
        test_reset();
        test_scan_timing();
        test_leading_zero();
        test_random_inputs();
        test_dash();
        test_reset_mid();
`ifdef SEG_OVF_DP_EN
        test_ovf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
